// File: rtl/tsmp_tx_framer.sv
// TSMP transmit framer: builds a 16-byte header, streams the payload from a
// show-ahead FIFO, zero-pads short frames up to the Ethernet minimum, and
// enforces an inter-frame gap before the next request is accepted.
module tsmp_tx_framer #(
    parameter int unsigned  DATA_WIDTH = 9,
    parameter logic [15:0]  ETHERTYPE  = 16'hFF01,
    parameter int unsigned  LEN_W      = 11,
    parameter int unsigned  MAX_LEN    = 1500,
    parameter int unsigned  MIN_FRAME  = 60,
    parameter int unsigned  IFG_CYCLES = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_tx_start,
    input  logic [LEN_W-1:0]      iv_tx_len,
    input  logic [47:0]           iv_dmac,
    input  logic [47:0]           iv_smac,
    input  logic [7:0]            iv_type,
    input  logic [7:0]            iv_subtype,
    output logic                  o_tx_rdy,
    input  logic [7:0]            iv_fifo_rdata,
    input  logic                  i_fifo_empty,
    output logic                  o_fifo_rd,
    output logic [DATA_WIDTH-1:0] ov_data,
    output logic                  o_data_wr,
    output logic                  o_tx_done,
    output logic                  o_tx_err,
    output logic                  o_underflow
);

    localparam int unsigned HDR_LEN = 16;
    // One extra bit so header + payload never wraps the word counter.
    localparam int unsigned CNT_W   = LEN_W + 1;
    localparam int unsigned IFG_W   = (IFG_CYCLES < 1) ? 1 : $clog2(IFG_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StPay,
        StPad,
        StIfg
    } state_e;

    state_e           state_q, state_d;
    logic [47:0]      dmac_q, dmac_d;
    logic [47:0]      smac_q, smac_d;
    logic [7:0]       type_q, type_d;
    logic [7:0]       subtype_q, subtype_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] word_idx_q, word_idx_d;
    logic [LEN_W-1:0] pay_rem_q, pay_rem_d;
    logic [IFG_W-1:0] ifg_cnt_q, ifg_cnt_d;

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  data_wr_q, data_wr_d;
    logic                  tx_done_q, tx_done_d;
    logic                  tx_err_q, tx_err_d;
    logic                  underflow_q, underflow_d;

    logic             emit;
    logic             marker;
    logic [7:0]       byte_d;
    logic [7:0]       hdr_byte;
    logic             fifo_rd;
    logic             last_word;
    logic [CNT_W-1:0] req_sum;
    logic [CNT_W-1:0] req_total;

    // word_idx_q is the index of the word being produced in this cycle.
    assign last_word = (word_idx_q == total_q - CNT_W'(1));

    // Frame length for the incoming request: max(16 + len, MIN_FRAME).
    assign req_sum   = CNT_W'(iv_tx_len) + CNT_W'(HDR_LEN);
    assign req_total = (req_sum < CNT_W'(MIN_FRAME)) ? CNT_W'(MIN_FRAME) : req_sum;

    // Header byte selection from the latched request fields (byte 0 is sent
    // straight from the inputs in the accept cycle).
    always_comb begin
        hdr_byte = 8'h00;
        case (word_idx_q[3:0])
            4'd0:    hdr_byte = dmac_q[47:40];
            4'd1:    hdr_byte = dmac_q[39:32];
            4'd2:    hdr_byte = dmac_q[31:24];
            4'd3:    hdr_byte = dmac_q[23:16];
            4'd4:    hdr_byte = dmac_q[15:8];
            4'd5:    hdr_byte = dmac_q[7:0];
            4'd6:    hdr_byte = smac_q[47:40];
            4'd7:    hdr_byte = smac_q[39:32];
            4'd8:    hdr_byte = smac_q[31:24];
            4'd9:    hdr_byte = smac_q[23:16];
            4'd10:   hdr_byte = smac_q[15:8];
            4'd11:   hdr_byte = smac_q[7:0];
            4'd12:   hdr_byte = ETHERTYPE[15:8];
            4'd13:   hdr_byte = ETHERTYPE[7:0];
            4'd14:   hdr_byte = type_q;
            default: hdr_byte = subtype_q;
        endcase
    end

    // Next-state logic and the word to be registered onto the bus next cycle.
    always_comb begin
        state_d     = state_q;
        dmac_d      = dmac_q;
        smac_d      = smac_q;
        type_d      = type_q;
        subtype_d   = subtype_q;
        total_d     = total_q;
        word_idx_d  = word_idx_q;
        pay_rem_d   = pay_rem_q;
        ifg_cnt_d   = ifg_cnt_q;
        emit        = 1'b0;
        marker      = 1'b0;
        byte_d      = 8'h00;
        fifo_rd     = 1'b0;
        tx_done_d   = 1'b0;
        tx_err_d    = 1'b0;
        underflow_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (i_tx_start) begin
                    dmac_d    = iv_dmac;
                    smac_d    = iv_smac;
                    type_d    = iv_type;
                    subtype_d = iv_subtype;
                    if (iv_tx_len > LEN_W'(MAX_LEN)) begin
                        tx_err_d = 1'b1;
                    end else begin
                        // Word 0 leaves in the accept cycle so it is on the bus at N+1.
                        emit       = 1'b1;
                        marker     = 1'b1;
                        byte_d     = iv_dmac[47:40];
                        word_idx_d = CNT_W'(1);
                        pay_rem_d  = iv_tx_len;
                        total_d    = req_total;
                        state_d    = StHdr;
                    end
                end
            end

            StHdr: begin
                emit       = 1'b1;
                byte_d     = hdr_byte;
                word_idx_d = word_idx_q + CNT_W'(1);
                if (word_idx_q == CNT_W'(HDR_LEN - 1)) begin
                    // A zero-length payload always needs padding to reach the minimum.
                    state_d = (pay_rem_q != '0) ? StPay : StPad;
                end
            end

            StPay: begin
                emit = 1'b1;
                if (i_fifo_empty) begin
                    // Missing byte: send zero, keep the frame length fixed.
                    underflow_d = 1'b1;
                end else begin
                    fifo_rd = 1'b1;
                    byte_d  = iv_fifo_rdata;
                end
                pay_rem_d  = pay_rem_q - LEN_W'(1);
                word_idx_d = word_idx_q + CNT_W'(1);
                if (last_word) begin
                    marker    = 1'b1;
                    tx_done_d = 1'b1;
                    ifg_cnt_d = IFG_W'(IFG_CYCLES);
                    state_d   = StIfg;
                end else if (pay_rem_q == LEN_W'(1)) begin
                    state_d = StPad;
                end
            end

            StPad: begin
                emit       = 1'b1;
                word_idx_d = word_idx_q + CNT_W'(1);
                if (last_word) begin
                    marker    = 1'b1;
                    tx_done_d = 1'b1;
                    ifg_cnt_d = IFG_W'(IFG_CYCLES);
                    state_d   = StIfg;
                end
            end

            StIfg: begin
                // The first gap cycle still shows the end-marker word, so the
                // count runs IFG_CYCLES+1 cycles to leave IFG_CYCLES idle ones.
                if (ifg_cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    ifg_cnt_d = ifg_cnt_q - IFG_W'(1);
                end
            end

            default: state_d = StIdle;
        endcase

        data_wr_d = emit;
        data_d    = emit ? DATA_WIDTH'({marker, byte_d}) : '0;
    end

    // State, latched request and registered bus outputs; synchronous reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            dmac_q      <= '0;
            smac_q      <= '0;
            type_q      <= '0;
            subtype_q   <= '0;
            total_q     <= '0;
            word_idx_q  <= '0;
            pay_rem_q   <= '0;
            ifg_cnt_q   <= '0;
            data_q      <= '0;
            data_wr_q   <= 1'b0;
            tx_done_q   <= 1'b0;
            tx_err_q    <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dmac_q      <= dmac_d;
            smac_q      <= smac_d;
            type_q      <= type_d;
            subtype_q   <= subtype_d;
            total_q     <= total_d;
            word_idx_q  <= word_idx_d;
            pay_rem_q   <= pay_rem_d;
            ifg_cnt_q   <= ifg_cnt_d;
            data_q      <= data_d;
            data_wr_q   <= data_wr_d;
            tx_done_q   <= tx_done_d;
            tx_err_q    <= tx_err_d;
            underflow_q <= underflow_d;
        end
    end

    // Ready and FIFO pop are gated by reset so nothing is accepted or drained
    // while reset is held.
    assign o_tx_rdy    = (state_q == StIdle) & i_rst_n;
    assign o_fifo_rd   = fifo_rd & i_rst_n;
    assign ov_data     = data_q;
    assign o_data_wr   = data_wr_q;
    assign o_tx_done   = tx_done_q;
    assign o_tx_err    = tx_err_q;
    assign o_underflow = underflow_q;

endmodule

// File: tb/tb_tsmp_tx_framer.sv
// Scoreboard bench for tsmp_tx_framer: expected frames are built from the
// request fields and a snapshot of the FIFO model, then checked word by word.
module tb_tsmp_tx_framer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tx_start;
    logic [10:0] tx_len;
    logic [47:0] dmac;
    logic [47:0] smac;
    logic [7:0]  ttype;
    logic [7:0]  subtype;
    logic        tx_rdy;
    logic [7:0]  fifo_rdata = 8'h00;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd;
    logic [8:0]  data;
    logic        data_wr;
    logic        tx_done;
    logic        tx_err;
    logic        underflow;

    always #5 clk = ~clk;

    tsmp_tx_framer dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_tx_start    (tx_start),
        .iv_tx_len     (tx_len),
        .iv_dmac       (dmac),
        .iv_smac       (smac),
        .iv_type       (ttype),
        .iv_subtype    (subtype),
        .o_tx_rdy      (tx_rdy),
        .iv_fifo_rdata (fifo_rdata),
        .i_fifo_empty  (fifo_empty),
        .o_fifo_rd     (fifo_rd),
        .ov_data       (data),
        .o_data_wr     (data_wr),
        .o_tx_done     (tx_done),
        .o_tx_err      (tx_err),
        .o_underflow   (underflow)
    );

    typedef struct {
        logic [8:0] word;
        logic       done;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fifo_q[$];

    int checks = 0;
    int errors = 0;
    int words_seen = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int uf_cnt = 0;
    int rd_cnt = 0;
    logic in_frame = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Show-ahead FIFO model: head and empty flag settle one edge after a push/pop.
    always @(posedge clk) begin
        if (fifo_rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
        fifo_rdata <= (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Monitor: pops the scoreboard for every bus word and tallies pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fifo_rd)   rd_cnt++;
            if (underflow) uf_cnt++;
            if (tx_err)    err_cnt++;
            if (tx_done)   done_cnt++;
            if (in_frame) check("continuity", data_wr, 1);
            if (data_wr) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %03h, expected no word (t=%0t)",
                             data, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("word", data, e.word);
                    check("done", tx_done, e.done);
                end
                words_seen++;
                in_frame = !tx_done;
            end else if (tx_done) begin
                check("done_idle", tx_done, 0);
            end
        end else begin
            in_frame = 1'b0;
        end
    end

    // Reference frame: header, payload from the FIFO snapshot (zeros once it
    // runs dry), zero pad to 60 bytes; markers on first and last word.
    task automatic push_frame(input logic [47:0] dm, input logic [47:0] sm,
                              input logic [7:0] ty, input logic [7:0] st, input int len);
        logic [7:0] b[$];
        int         avail;
        int         total;
        exp_t       e;
        for (int i = 0; i < 6; i++) b.push_back(dm[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) b.push_back(sm[47-8*i -: 8]);
        b.push_back(8'hFF);
        b.push_back(8'h01);
        b.push_back(ty);
        b.push_back(st);
        avail = fifo_q.size();
        for (int i = 0; i < len; i++) b.push_back((i < avail) ? fifo_q[i] : 8'h00);
        while (b.size() < 60) b.push_back(8'h00);
        total = b.size();
        for (int i = 0; i < total; i++) begin
            e.word = {((i == 0) || (i == total - 1)), b[i]};
            e.done = (i == total - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_rdy();
        int c;
        c = 0;
        while (!tx_rdy && c < 3000) begin
            @(negedge clk);
            #1;
            c++;
        end
        if (!tx_rdy) check("rdy_timeout", tx_rdy, 1);
    endtask

    task automatic start_frame(input logic [47:0] dm, input logic [47:0] sm,
                               input logic [7:0] ty, input logic [7:0] st, input int len);
        wait_rdy();
        dmac     = dm;
        smac     = sm;
        ttype    = ty;
        subtype  = st;
        tx_len   = 11'(len);
        tx_start = 1'b1;
        if (len <= 1500) push_frame(dm, sm, ty, st, len);
        @(negedge clk);
        #1;
        tx_start = 1'b0;
        // Fields must be latched; scramble them after the start cycle.
        dmac     = {$urandom, $urandom};
        smac     = {$urandom, $urandom};
        ttype    = 8'($urandom);
        subtype  = 8'($urandom);
        tx_len   = 11'($urandom);
    endtask

    task automatic wait_done(input int base);
        int c;
        c = 0;
        while (done_cnt == base && c < 4000) begin
            @(negedge clk);
            #1;
            c++;
        end
        check("frame_done", done_cnt - base, 1);
    endtask

    task automatic run_frame(input logic [47:0] dm, input logic [47:0] sm,
                             input logic [7:0] ty, input logic [7:0] st,
                             input int len, input int nbytes, input bit seq);
        int b_rd, b_uf, b_w, b_d, got, total;
        b_rd = rd_cnt;
        b_uf = uf_cnt;
        b_w  = words_seen;
        b_d  = done_cnt;
        for (int i = 0; i < nbytes; i++) fifo_q.push_back(seq ? 8'(i) : 8'($urandom));
        got   = (nbytes < len) ? nbytes : len;
        total = (16 + len < 60) ? 60 : 16 + len;
        start_frame(dm, sm, ty, st, len);
        wait_done(b_d);
        check("fifo_rd_count", rd_cnt - b_rd, got);
        check("underflow_count", uf_cnt - b_uf, len - got);
        check("frame_length", words_seen - b_w, total);
        check("scoreboard_empty", exp_q.size(), 0);
        fifo_q.delete();
    endtask

    initial begin
        int b_err, b_w, b_d, cnt, len;
        rst_n    = 1'b0;
        tx_start = 1'b0;
        tx_len   = '0;
        dmac     = '0;
        smac     = '0;
        ttype    = '0;
        subtype  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_rdy", tx_rdy, 0);
        check("rst_data_wr", data_wr, 0);
        check("rst_data", data, 0);
        check("rst_fifo_rd", fifo_rd, 0);
        check("rst_pulses", {tx_done, tx_err, underflow}, 0);
        rst_n = 1'b1;
        #1;
        check("rdy_after_release", tx_rdy, 1);
        @(negedge clk);
        #1;

        // Minimum-size padding
        run_frame(48'h0101_0000_0000, 48'h0, 8'h00, 8'h00, 4, 4, 1'b1);
        // Long payload, no pad
        run_frame({$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom), 8'($urandom),
                  66, 66, 1'b1);
        // Boundaries: empty payload, exact minimum, maximum length
        run_frame({$urandom, $urandom}, {$urandom, $urandom}, 8'h11, 8'h22, 0, 0, 1'b0);
        run_frame({$urandom, $urandom}, {$urandom, $urandom}, 8'h33, 8'h44, 44, 44, 1'b0);
        run_frame({$urandom, $urandom}, {$urandom, $urandom}, 8'h55, 8'h66, 1500, 1500, 1'b0);

        // Oversize request
        wait_rdy();
        b_err = err_cnt;
        b_w   = words_seen;
        tx_len   = 11'd1501;
        tx_start = 1'b1;
        @(negedge clk);
        #1;
        tx_start = 1'b0;
        check("oversize_err", tx_err, 1);
        check("oversize_no_data", data_wr, 0);
        check("oversize_rdy", tx_rdy, 1);
        repeat (20) @(negedge clk);
        #1;
        check("oversize_err_count", err_cnt - b_err, 1);
        check("oversize_no_words", words_seen - b_w, 0);

        // Start during HDR is ignored (oversize length would otherwise error)
        b_err = err_cnt;
        b_d   = done_cnt;
        for (int i = 0; i < 20; i++) fifo_q.push_back(8'($urandom));
        start_frame({$urandom, $urandom}, {$urandom, $urandom}, 8'hA5, 8'h5A, 20);
        @(negedge clk);
        #1;
        tx_len   = 11'd1501;
        tx_start = 1'b1;
        @(negedge clk);
        #1;
        tx_start = 1'b0;
        wait_done(b_d);
        repeat (30) @(negedge clk);
        #1;
        check("hdr_start_no_err", err_cnt - b_err, 0);
        check("hdr_start_no_frame", exp_q.size(), 0);
        fifo_q.delete();

        // Underflow: 50 byte payload, 40 available
        run_frame({$urandom, $urandom}, {$urandom, $urandom}, 8'h01, 8'h02, 50, 40, 1'b0);

        // IFG and back-to-back start held from the end marker
        b_d = done_cnt;
        for (int i = 0; i < 30; i++) fifo_q.push_back(8'($urandom));
        start_frame({$urandom, $urandom}, {$urandom, $urandom}, 8'h07, 8'h08, 30);
        wait_done(b_d);
        b_d = done_cnt;
        for (int i = 0; i < 10; i++) fifo_q.push_back(8'($urandom));
        dmac     = {$urandom, $urandom};
        smac     = {$urandom, $urandom};
        ttype    = 8'h09;
        subtype  = 8'h0A;
        tx_len   = 11'd10;
        tx_start = 1'b1;
        push_frame(dmac, smac, ttype, subtype, 10);
        cnt = 0;
        while (!tx_rdy && cnt < 50) begin
            @(negedge clk);
            #1;
            cnt++;
        end
        check("ifg_rdy_delay", cnt, 13);
        @(negedge clk);
        #1;
        tx_start = 1'b0;
        check("b2b_first_word", data_wr, 1);
        wait_done(b_d);
        check("b2b_scoreboard_empty", exp_q.size(), 0);
        fifo_q.delete();

        // Randomized frames, some short of FIFO data
        for (int k = 0; k < 6; k++) begin
            int nb;
            len = $urandom_range(0, 120);
            nb  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : len;
            run_frame({$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom), 8'($urandom),
                      len, nb, 1'b0);
        end

        // Mid-frame reset at payload word 20 (bus word 36)
        b_d = done_cnt;
        b_w = words_seen;
        for (int i = 0; i < 40; i++) fifo_q.push_back(8'($urandom));
        start_frame({$urandom, $urandom}, {$urandom, $urandom}, 8'h0B, 8'h0C, 40);
        cnt = 0;
        while (words_seen < b_w + 37 && cnt < 200) begin
            @(negedge clk);
            #1;
            cnt++;
        end
        check("reset_point", words_seen - b_w, 37);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("reset_stops_data", data_wr, 0);
        check("reset_no_done", tx_done, 0);
        check("reset_rdy_low", tx_rdy, 0);
        check("reset_fifo_not_drained", fifo_q.size(), 19);
        @(negedge clk);
        #1;
        exp_q.delete();
        fifo_q.delete();
        rst_n = 1'b1;
        #1;
        check("reset_rdy_after", tx_rdy, 1);
        check("reset_done_count", done_cnt - b_d, 0);
        @(negedge clk);
        #1;
        run_frame({$urandom, $urandom}, {$urandom, $urandom}, 8'h0D, 8'h0E, 8, 8, 1'b0);

        repeat (20) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
